// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
//
// Store FIFO sitting between the dcache memory port and dmem. Stores from the
// cache are queued and retired to dmem one per cycle whenever the port is not
// busy with a load. Loads forward from the youngest buffered store to the
// same word, otherwise they read dmem directly. A level 'flush' request
// drains the buffer completely and refuses new stores while it does so.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   reset    : synchronous active-low reset
//   c_addr   : cache-side address (word aligned, bits [1:0] ignored in compares)
//   c_wdata  : cache-side store data
//   c_wen    : cache store request
//   c_ren    : cache load request
//   c_rdata  : load data, combinational
//   c_ready  : request accepted this cycle, combinational
//   flush    : drain request, blocks new stores while active
//   empty    : registered, 1 when no entries are held
//   count    : registered occupancy
//   m_addr   : dmem address
//   m_wdata  : dmem write data
//   m_wen    : dmem write enable
//   m_rdata  : dmem combinational read data
module dcache_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW-1:0]          c_addr,
  input  logic [DW-1:0]          c_wdata,
  input  logic                   c_wen,
  input  logic                   c_ren,
  output logic [DW-1:0]          c_rdata,
  output logic                   c_ready,
  input  logic                   flush,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [AW-1:0]          m_addr,
  output logic [DW-1:0]          m_wdata,
  output logic                   m_wen,
  input  logic [DW-1:0]          m_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [PW-1:0]   head, tail;
  logic            drain;
  logic            store_open;
  logic            enq;
  logic [CW-1:0]   count_next;
  logic            hit;
  logic [DW-1:0]   fwd_data;
  logic [PW-1:0]   idx;

  // A load owns the dmem port for the cycle, so draining pauses while c_ren
  // is high. A full buffer can still take a store when the head retires in
  // the same cycle. The raw flush input blocks stores too, so the first
  // flush cycle already refuses a store before the state register has moved.
  always_comb begin
    drain      = ~empty & ~c_ren;
    store_open = ((count < FULL) | drain) & ~flush & (state != FLUSH);
    enq        = c_wen & store_open;
    c_ready    = c_wen ? store_open : 1'b1;
    count_next = count + CW'(enq) - CW'(drain);
  end

  always_comb begin
    m_wen   = drain;
    m_addr  = c_ren ? c_addr : addr_q[head];
    m_wdata = data_q[head];
  end

  // Walk the live entries oldest to youngest; a later match overrides an
  // earlier one so the youngest store to the word wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx][AW-1:2] == c_addr[AW-1:2])) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
    c_rdata = hit ? fwd_data : m_rdata;
  end

  // Once flushing starts it holds until the buffer is empty, even if the
  // flush request drops early.
  always_comb begin
    state_next = state;
    if (count_next == '0) begin
      state_next = IDLE;
    end else if (flush || (state == FLUSH)) begin
      state_next = FLUSH;
    end else begin
      state_next = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
    end else begin
      state <= state_next;
      if (enq) begin
        tail <= tail + PW'(1);
      end
      if (drain) begin
        head <= head + PW'(1);
      end
      count <= count_next;
      empty <= (count_next == '0);
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (reset && enq) begin
      addr_q[tail] <= c_addr;
      data_q[tail] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
module tb_dcache_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_wen;
  logic        c_ren;
  logic [31:0] c_rdata;
  logic        c_ready;
  logic        flush;
  logic        empty;
  logic [2:0]  count;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_wen;
  logic [31:0] m_rdata;

  int errors = 0;
  int checks = 0;

  // Simple word-addressed dmem: combinational read, write on the rising edge.
  logic [31:0] ram [64] = '{default: 32'h0};

  assign m_rdata = ram[m_addr[7:2]];

  always @(posedge clk) begin
    if (m_wen === 1'b1) ram[m_addr[7:2]] <= m_wdata;
  end

  always #5 clk = ~clk;

  dcache_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_wen   (c_wen),
    .c_ren   (c_ren),
    .c_rdata (c_rdata),
    .c_ready (c_ready),
    .flush   (flush),
    .empty   (empty),
    .count   (count),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wen   (m_wen),
    .m_rdata (m_rdata)
  );

  // Directed vectors: one row per clock cycle, expectations observed mid-cycle.
  typedef struct {
    logic        rst;
    logic        wen;
    logic        ren;
    logic        fl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic        exp_ready;
    logic        exp_mwen;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_count;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a queue of pending stores plus the memory image that
  // dmem must hold once those stores have retired in program order.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          m_flushing = 1'b0;
  logic [31:0] model_mem [64];

  task automatic addVec(input logic rst, input logic wen, input logic ren, input logic fl,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic chk,
                        input logic rdy, input logic mw, input logic [31:0] ma, input logic [31:0] md,
                        input logic crd, input logic [31:0] rd, input logic [2:0] cnt, input logic emp);
    vec_t v;
    v = '{rst, wen, ren, fl, addr, wdata, chk, rdy, mw, ma, md, crd, rd, cnt, emp};
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, input logic wen, input logic ren, input logic fl,
                               input logic [31:0] addr, input logic [31:0] wdata);
    reset   = rst;
    c_wen   = wen;
    c_ren   = ren;
    flush   = fl;
    c_addr  = addr;
    c_wdata = wdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle against the reference model: drive, compare mid-cycle, then
  // advance the model across the rising edge.
  task automatic modelStep(input logic rst, input logic wen, input logic ren, input logic fl,
                           input logic [31:0] addr, input logic [31:0] wdata, input int cyc);
    int          size;
    bit          exp_drain;
    bit          exp_ready;
    logic [31:0] exp_rd;
    applyStimulus(rst, wen, ren, fl, addr, wdata);
    @(negedge clk);
    size      = mq.size();
    exp_drain = (size != 0) && !ren;
    exp_ready = wen ? (((size < DEPTH) || exp_drain) && !fl && !m_flushing) : 1'b1;
    checkOutput($sformatf("cyc%0d c_ready", cyc), 32'(c_ready), 32'(exp_ready));
    checkOutput($sformatf("cyc%0d m_wen", cyc), 32'(m_wen), 32'(exp_drain));
    checkOutput($sformatf("cyc%0d count", cyc), 32'(count), 32'(size));
    checkOutput($sformatf("cyc%0d empty", cyc), 32'(empty), 32'(size == 0));
    if (exp_drain) begin
      checkOutput($sformatf("cyc%0d m_addr", cyc), m_addr, mq[0].a);
      checkOutput($sformatf("cyc%0d m_wdata", cyc), m_wdata, mq[0].d);
    end
    if (ren && !wen) begin
      exp_rd = model_mem[addr[7:2]];
      for (int i = 0; i < size; i++) begin
        if (mq[i].a[31:2] == addr[31:2]) exp_rd = mq[i].d;
      end
      checkOutput($sformatf("cyc%0d c_rdata", cyc), c_rdata, exp_rd);
      checkOutput($sformatf("cyc%0d load m_addr", cyc), m_addr, addr);
    end
    @(posedge clk);
    if (exp_drain) begin
      model_mem[mq[0].a[7:2]] = mq[0].d;
      void'(mq.pop_front());
    end
    if (!rst) begin
      mq.delete();
      m_flushing = 1'b0;
    end else begin
      if (wen && exp_ready) mq.push_back('{addr, wdata});
      if (mq.size() == 0) m_flushing = 1'b0;
      else if (fl) m_flushing = 1'b1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    int   k;
    int   budget;

    // Reset, single store retiring, back-to-back stores with forwarding.
    addVec(0,0,0,0, 32'h0,  32'h0,   0, 1,0,32'h0, 32'h0,   0,32'h0, 3'd0,1);
    addVec(0,0,0,0, 32'h0,  32'h0,   1, 1,0,32'h0, 32'h0,   0,32'h0, 3'd0,1);
    addVec(1,1,0,0, 32'h10, 32'hAA,  1, 1,0,32'h0, 32'h0,   0,32'h0, 3'd0,1);
    addVec(1,0,0,0, 32'h0,  32'h0,   1, 1,1,32'h10,32'hAA,  0,32'h0, 3'd1,0);
    addVec(1,0,0,0, 32'h0,  32'h0,   1, 1,0,32'h0, 32'h0,   0,32'h0, 3'd0,1);
    addVec(1,1,0,0, 32'h20, 32'h1,   1, 1,0,32'h0, 32'h0,   0,32'h0, 3'd0,1);
    addVec(1,1,0,0, 32'h20, 32'h2,   1, 1,1,32'h20,32'h1,   0,32'h0, 3'd1,0);
    addVec(1,0,1,0, 32'h20, 32'h0,   1, 1,0,32'h0, 32'h0,   1,32'h2, 3'd1,0);
    addVec(1,0,0,0, 32'h0,  32'h0,   1, 1,1,32'h20,32'h2,   0,32'h0, 3'd1,0);
    addVec(1,0,1,0, 32'h20, 32'h0,   1, 1,0,32'h0, 32'h0,   1,32'h2, 3'd0,1);
    // Fill while loads hold the port, then a store into the full buffer.
    for (k = 0; k < 4; k++) begin
      addVec(1,1,1,0, 32'h40 + 32'(4*k), 32'h100 + 32'(k), 1, 1,0,32'h0,32'h0, 0,32'h0, 3'(k), (k == 0));
    end
    addVec(1,1,1,0, 32'h50, 32'h104, 1, 0,0,32'h0, 32'h0,   0,32'h0, 3'd4,0);
    addVec(1,1,1,0, 32'h50, 32'h104, 1, 0,0,32'h0, 32'h0,   0,32'h0, 3'd4,0);
    addVec(1,1,0,0, 32'h50, 32'h104, 1, 1,1,32'h40,32'h100, 0,32'h0, 3'd4,0);
    addVec(1,0,0,0, 32'h0,  32'h0,   1, 1,1,32'h44,32'h101, 0,32'h0, 3'd4,0);
    addVec(1,0,0,0, 32'h0,  32'h0,   1, 1,1,32'h48,32'h102, 0,32'h0, 3'd3,0);
    addVec(1,0,0,0, 32'h0,  32'h0,   1, 1,1,32'h4C,32'h103, 0,32'h0, 3'd2,0);
    addVec(1,0,0,0, 32'h0,  32'h0,   1, 1,1,32'h50,32'h104, 0,32'h0, 3'd1,0);
    addVec(1,0,0,0, 32'h0,  32'h0,   1, 1,0,32'h0, 32'h0,   0,32'h0, 3'd0,1);
    // Three buffered stores, then flush with a store held.
    for (k = 0; k < 3; k++) begin
      addVec(1,1,1,0, 32'h60 + 32'(4*k), 32'h200 + 32'(k), 1, 1,0,32'h0,32'h0, 0,32'h0, 3'(k), (k == 0));
    end
    addVec(1,1,0,1, 32'h6C, 32'h2FF, 1, 0,1,32'h60,32'h200, 0,32'h0, 3'd3,0);
    addVec(1,1,0,1, 32'h6C, 32'h2FF, 1, 0,1,32'h64,32'h201, 0,32'h0, 3'd2,0);
    addVec(1,1,0,1, 32'h6C, 32'h2FF, 1, 0,1,32'h68,32'h202, 0,32'h0, 3'd1,0);
    addVec(1,0,0,1, 32'h0,  32'h0,   1, 1,0,32'h0, 32'h0,   0,32'h0, 3'd0,1);
    addVec(1,0,0,0, 32'h0,  32'h0,   1, 1,0,32'h0, 32'h0,   0,32'h0, 3'd0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.rst, v.wen, v.ren, v.fl, v.addr, v.wdata);
      @(negedge clk);
      if (v.chk) begin
        checkOutput($sformatf("row%0d c_ready", i), 32'(c_ready), 32'(v.exp_ready));
        checkOutput($sformatf("row%0d m_wen", i), 32'(m_wen), 32'(v.exp_mwen));
        checkOutput($sformatf("row%0d count", i), 32'(count), 32'(v.exp_count));
        checkOutput($sformatf("row%0d empty", i), 32'(empty), 32'(v.exp_empty));
        if (v.exp_mwen) begin
          checkOutput($sformatf("row%0d m_addr", i), m_addr, v.exp_maddr);
          checkOutput($sformatf("row%0d m_wdata", i), m_wdata, v.exp_mwdata);
        end
        if (v.chk_rd) checkOutput($sformatf("row%0d c_rdata", i), c_rdata, v.exp_rdata);
      end
      @(posedge clk);
      #1;
    end

    checkOutput("dmem word 0x10", ram[4], 32'hAA);
    checkOutput("dmem word 0x20", ram[8], 32'h2);
    checkOutput("dmem word 0x40", ram[16], 32'h100);
    checkOutput("dmem word 0x50", ram[20], 32'h104);
    checkOutput("dmem word 0x60", ram[24], 32'h200);
    checkOutput("dmem word 0x68", ram[26], 32'h202);
    checkOutput("dmem word 0x6C", ram[27], 32'h0);

    // Reset arriving mid-drain: the in-flight head write lands, the rest vanish.
    applyStimulus(1, 1, 1, 0, 32'h80, 32'h300);
    @(posedge clk); #1;
    applyStimulus(1, 1, 1, 0, 32'h84, 32'h301);
    @(posedge clk); #1;
    applyStimulus(1, 1, 1, 0, 32'h88, 32'h302);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rst-drain m_wen", 32'(m_wen), 32'h1);
    checkOutput("rst-drain m_addr", m_addr, 32'h80);
    @(posedge clk); #1;
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("post-rst count", 32'(count), 32'h0);
    checkOutput("post-rst empty", 32'(empty), 32'h1);
    checkOutput("post-rst m_wen", 32'(m_wen), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("dmem word 0x80", ram[32], 32'h300);
    checkOutput("dmem word 0x84", ram[33], 32'h0);
    checkOutput("dmem word 0x88", ram[34], 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 64; i++) model_mem[i] = ram[i];
    for (int c = 0; c < 400; c++) begin
      modelStep(($urandom_range(0, 79) != 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 11) == 0),
                32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
                $urandom, c);
    end

    // Force everything out, then the memory image must match program order.
    budget = 0;
    while (mq.size() != 0 && budget < 20) begin
      modelStep(1, 0, 0, 1, 32'h0, 32'h0, 1000 + budget);
      budget++;
    end
    checks++;
    if (mq.size() != 0) begin
      errors++;
      $display("[TB] FAIL final drain: %0d entries left, required 0", mq.size());
    end
    modelStep(1, 0, 0, 0, 32'h0, 32'h0, 2000);
    for (int i = 0; i < 64; i++) begin
      checkOutput($sformatf("final dmem[%0d]", i), ram[i], model_mem[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
